// File: rtl/conv_win_sched_pkg.sv
// Package cnn_l1_pkg
// Shared types and elaboration helpers for the layer-1 convolution scheduler.
//   sched_state_t : scheduler FSM states
//   out_dim       : number of valid window positions along one axis
//   addr_w_ok     : checks that an address width covers a whole feature map
package cnn_l1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        EMIT,
        DONE
    } sched_state_t;

    // Valid (non-padded) output size along one axis for a KxK kernel.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // True when 2**addr_w can address every pixel of a w x h map.
    function automatic bit addr_w_ok(input int addr_w, input int w, input int h);
        longint span;
        span = longint'(1) << addr_w;
        return span >= longint'(w) * longint'(h);
    endfunction

endpackage

// File: rtl/conv_win_sched_if.sv
// Interface conv_win_sched_if
// Bundles the scheduler's datapath-facing signals.
//   pix_addr/pix_rd          : pixel buffer read port
//   mac_clr/mac_en/mac_last  : MAC array control strobes
//   out_valid/out_ready      : result handshake, out_row/out_col name the window
// master = scheduler side, slave = pixel buffer / MAC / result consumer side.
interface conv_win_sched_if #(
    parameter int ADDR_W = 10
);

    logic [ADDR_W-1:0] pix_addr;
    logic              pix_rd;
    logic              mac_clr;
    logic              mac_en;
    logic              mac_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_row;
    logic [7:0]        out_col;

    modport master (
        output pix_addr, pix_rd, mac_clr, mac_en, mac_last,
        output out_valid, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  pix_addr, pix_rd, mac_clr, mac_en, mac_last,
        input  out_valid, out_row, out_col,
        output out_ready
    );

endinterface

// File: rtl/conv_win_sched_nest_ctr.sv
// Module conv_nest_ctr
// Two-dimensional wrap counter: inner counts 0..INNER_MAX-1, and on wrap the
// outer counts 0..OUTER_MAX-1. Both wrap back to zero after the last position.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear to (0,0), wins over inc
//   inc        : advance one position
//   inner/outer: current position
//   inner_wrap : inner is at its final value
//   last       : both inner and outer are at their final values
module conv_nest_ctr #(
    parameter int INNER_MAX = 5,
    parameter int OUTER_MAX = 5,
    parameter int W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] inner,
    output logic [W-1:0] outer,
    output logic         inner_wrap,
    output logic         last
);

    assign inner_wrap = (inner == W'(INNER_MAX - 1));
    assign last       = inner_wrap && (outer == W'(OUTER_MAX - 1));

    // Position register; the final position rolls over to (0,0) so the
    // next pass starts clean without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inner <= '0;
            outer <= '0;
        end else if (clr) begin
            inner <= '0;
            outer <= '0;
        end else if (inc) begin
            if (inner_wrap) begin
                inner <= '0;
                outer <= last ? '0 : outer + W'(1);
            end else begin
                inner <= inner + W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_win_sched.sv
// Module conv_win_sched
// Sequences the layer-1 convolution over one input feature map: walks every
// valid KxK window, issues one pixel read per tap with MAC clear/enable/last,
// waits out the MAC pipeline and offers each result with valid/ready.
//   conv_sched_clk/rst  : clock, asynchronous active-high reset
//   conv_sched_start_i  : start pulse, honoured only when idle
//   conv_sched_abort_i  : synchronous abort back to idle
//   bus (master)        : pixel read port, MAC strobes, result handshake
//   conv_sched_busy_o   : high whenever not idle
//   conv_sched_done_o   : one-cycle pulse after the last result is accepted
module conv_win_sched
    import cnn_l1_pkg::*;
#(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int K       = 5,
    parameter int MAC_LAT = 3,
    parameter int ADDR_W  = 10
) (
    input  logic                    conv_sched_clk,
    input  logic                    conv_sched_rst,
    input  logic                    conv_sched_start_i,
    input  logic                    conv_sched_abort_i,
    conv_win_sched_if.master        bus,
    output logic                    conv_sched_busy_o,
    output logic                    conv_sched_done_o
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);

    if (!addr_w_ok(ADDR_W, IMG_W, IMG_H)) begin : g_bad_addr_w
        $error("conv_win_sched: ADDR_W too small for IMG_W*IMG_H");
    end
    if (MAC_LAT < 1 || MAC_LAT > 15) begin : g_bad_mac_lat
        $error("conv_win_sched: MAC_LAT must be 1..15");
    end

    sched_state_t      state;
    logic [3:0]        wait_cnt;
    logic              last_win_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic              pix_rd_q;
    logic              mac_clr_q;
    logic              mac_last_q;
    logic              out_valid_q;
    logic [7:0]        out_row_q;
    logic [7:0]        out_col_q;

    logic [7:0]        tap_kx;
    logic [7:0]        tap_ky;
    logic              tap_kx_wrap;
    logic              tap_last;
    logic [7:0]        win_col;
    logic [7:0]        win_row;
    logic              win_col_wrap;
    logic              win_last;
    logic              issue;
    logic              ctr_clr;
    logic              tap_first;
    logic [ADDR_W-1:0] pix_addr_calc;
    logic              unused_wraps;

    // The tap counter always holds the tap to be issued next, so a tap
    // is issued and the counter advanced on the same edge. The window
    // counter advances as soon as a window's final tap is issued; the
    // window being reported is kept separately in out_row/out_col.
    always_comb begin
        issue = 1'b0;
        if (!conv_sched_abort_i) begin
            case (state)
                IDLE:    issue = conv_sched_start_i;
                LOAD:    issue = !mac_last_q;
                EMIT:    issue = bus.out_ready && !last_win_q;
                default: issue = 1'b0;
            endcase
        end
    end

    assign ctr_clr   = conv_sched_abort_i || (state == DONE);
    assign tap_first = (tap_kx == 8'd0) && (tap_ky == 8'd0);

    conv_nest_ctr #(
        .INNER_MAX (K),
        .OUTER_MAX (K),
        .W         (8)
    ) u_tap_ctr (
        .clk        (conv_sched_clk),
        .rst        (conv_sched_rst),
        .clr        (ctr_clr),
        .inc        (issue),
        .inner      (tap_kx),
        .outer      (tap_ky),
        .inner_wrap (tap_kx_wrap),
        .last       (tap_last)
    );

    conv_nest_ctr #(
        .INNER_MAX (OUT_W),
        .OUTER_MAX (OUT_H),
        .W         (8)
    ) u_win_ctr (
        .clk        (conv_sched_clk),
        .rst        (conv_sched_rst),
        .clr        (ctr_clr),
        .inc        (issue && tap_last),
        .inner      (win_col),
        .outer      (win_row),
        .inner_wrap (win_col_wrap),
        .last       (win_last)
    );

    // Only the combined last flags matter here; the per-axis wraps are
    // sunk so the counters keep one shared port list.
    assign unused_wraps = tap_kx_wrap ^ win_col_wrap;

    assign pix_addr_calc = (ADDR_W'(win_row) + ADDR_W'(tap_ky)) * ADDR_W'(IMG_W)
                         + ADDR_W'(win_col) + ADDR_W'(tap_kx);

    // Scheduler FSM with registered outputs. Strobes default low each
    // cycle; out_valid, busy and the window coordinates hold until a
    // transition changes them, which keeps the result stable under
    // back-pressure. Abort overrides every transition.
    always_ff @(posedge conv_sched_clk or posedge conv_sched_rst) begin
        if (conv_sched_rst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            last_win_q        <= 1'b0;
            pix_addr_q        <= '0;
            pix_rd_q          <= 1'b0;
            mac_clr_q         <= 1'b0;
            mac_last_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            out_row_q         <= '0;
            out_col_q         <= '0;
            conv_sched_busy_o <= 1'b0;
            conv_sched_done_o <= 1'b0;
        end else if (conv_sched_abort_i) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            last_win_q        <= 1'b0;
            pix_addr_q        <= '0;
            pix_rd_q          <= 1'b0;
            mac_clr_q         <= 1'b0;
            mac_last_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            out_row_q         <= '0;
            out_col_q         <= '0;
            conv_sched_busy_o <= 1'b0;
            conv_sched_done_o <= 1'b0;
        end else begin
            pix_rd_q          <= 1'b0;
            mac_clr_q         <= 1'b0;
            mac_last_q        <= 1'b0;
            conv_sched_done_o <= 1'b0;

            if (issue) begin
                pix_rd_q   <= 1'b1;
                pix_addr_q <= pix_addr_calc;
                mac_clr_q  <= tap_first;
                mac_last_q <= tap_last;
                if (tap_first) begin
                    out_row_q  <= win_row;
                    out_col_q  <= win_col;
                    last_win_q <= win_last;
                end
            end

            case (state)
                IDLE: begin
                    if (conv_sched_start_i) begin
                        state             <= LOAD;
                        conv_sched_busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (mac_last_q) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(MAC_LAT - 1)) begin
                        state       <= EMIT;
                        out_valid_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_win_q) begin
                            state             <= DONE;
                            conv_sched_done_o <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state             <= IDLE;
                    conv_sched_busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pix_addr  = pix_addr_q;
    assign bus.pix_rd    = pix_rd_q;
    assign bus.mac_en    = pix_rd_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_conv_win_sched.sv
// Testbench tb_conv_win_sched
// Directed bench for conv_win_sched on a 6x6 map with a 3x3 kernel and a
// two-cycle MAC latency (4x4 windows, 12 cycles per window). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_conv_win_sched;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;

    int n_compared;
    int n_mismatched;
    int cyc;

    conv_win_sched_if #(.ADDR_W(10)) bus ();

    conv_win_sched #(
        .IMG_W   (6),
        .IMG_H   (6),
        .K       (3),
        .MAC_LAT (2),
        .ADDR_W  (10)
    ) dut (
        .conv_sched_clk     (clk),
        .conv_sched_rst     (rst),
        .conv_sched_start_i (start),
        .conv_sched_abort_i (abort),
        .bus                (bus),
        .conv_sched_busy_o  (busy),
        .conv_sched_done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic a, input logic rdy);
        start         = s;
        abort         = a;
        bus.out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Entered in the tap-0 cycle of window (r,c); leaves in its EMIT cycle.
    // start_at names a tap (0..8) or the EMIT cycle (9) to pulse start in.
    task automatic runWindow(input int r, input int c, input int start_at);
        for (int t = 0; t < 9; t++) begin
            if (t == start_at) start = 1'b1;
            checkOutput($sformatf("w%0d_%0d_t%0d_addr", r, c, t), 32'(bus.pix_addr),
                        32'((r + t / 3) * 6 + c + t % 3));
            checkOutput($sformatf("w%0d_%0d_t%0d_rd", r, c, t), 32'(bus.pix_rd), 32'd1);
            checkOutput($sformatf("w%0d_%0d_t%0d_en", r, c, t), 32'(bus.mac_en), 32'd1);
            checkOutput($sformatf("w%0d_%0d_t%0d_clr", r, c, t), 32'(bus.mac_clr), 32'(t == 0));
            checkOutput($sformatf("w%0d_%0d_t%0d_last", r, c, t), 32'(bus.mac_last), 32'(t == 8));
            checkOutput($sformatf("w%0d_%0d_t%0d_valid", r, c, t), 32'(bus.out_valid), 32'd0);
            step();
            start = 1'b0;
        end
        for (int w = 0; w < 2; w++) begin
            checkOutput($sformatf("w%0d_%0d_wait%0d_rd", r, c, w), 32'(bus.pix_rd), 32'd0);
            checkOutput($sformatf("w%0d_%0d_wait%0d_valid", r, c, w), 32'(bus.out_valid), 32'd0);
            step();
        end
        if (start_at == 9) start = 1'b1;
        checkOutput($sformatf("w%0d_%0d_emit_valid", r, c), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("w%0d_%0d_emit_row", r, c), 32'(bus.out_row), 32'(r));
        checkOutput($sformatf("w%0d_%0d_emit_col", r, c), 32'(bus.out_col), 32'(c));
        checkOutput($sformatf("w%0d_%0d_emit_rd", r, c), 32'(bus.pix_rd), 32'd0);
    endtask

    // Full map with ready high, starting from idle; start pulses may be
    // injected into windows 0 and 1 to show they are ignored.
    task automatic runFullMap(input int pulse_w0, input int pulse_w1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 0;
        step();
        start = 1'b0;
        for (int w = 0; w < 16; w++) begin
            runWindow(w / 4, w % 4, (w == 0) ? pulse_w0 : ((w == 1) ? pulse_w1 : -1));
            if (w == 15) checkOutput("last_emit_cycle", 32'(cyc), 32'd192);
            step();
            start = 1'b0;
        end
        checkOutput("done_cycle", 32'(cyc), 32'd193);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_valid", 32'(bus.out_valid), 32'd0);
        step();
        checkOutput("after_done_busy", 32'(busy), 32'd0);
        checkOutput("after_done_done", 32'(done), 32'd0);
        checkOutput("after_done_rd", 32'(bus.pix_rd), 32'd0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        rst          = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_rd", 32'(bus.pix_rd), 32'd0);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_addr", 32'(bus.pix_addr), 32'd0);
        checkOutput("reset_row", 32'(bus.out_row), 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] tests 1-2: full map, ready high");
        runFullMap(-1, -1);
        step();

        $display("[TB] test 4: start pulsed in LOAD and EMIT");
        runFullMap(3, 9);
        step();

        $display("[TB] test 3: back-pressure in first EMIT");
        applyStimulus(1'b1, 1'b0, 1'b0);
        cyc = 0;
        step();
        start = 1'b0;
        runWindow(0, 0, -1);
        for (int i = 1; i < 5; i++) begin
            step();
            checkOutput($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("stall%0d_row", i), 32'(bus.out_row), 32'd0);
            checkOutput($sformatf("stall%0d_col", i), 32'(bus.out_col), 32'd0);
            checkOutput($sformatf("stall%0d_rd", i), 32'(bus.pix_rd), 32'd0);
        end
        step();
        bus.out_ready = 1'b1;
        checkOutput("ready_cycle", 32'(cyc), 32'd17);
        checkOutput("ready_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("ready_rd", 32'(bus.pix_rd), 32'd0);
        step();
        checkOutput("resume_rd", 32'(bus.pix_rd), 32'd1);
        checkOutput("resume_addr", 32'(bus.pix_addr), 32'd1);
        checkOutput("resume_clr", 32'(bus.mac_clr), 32'd1);
        checkOutput("resume_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        abort = 1'b0;
        checkOutput("stall_abort_busy", 32'(busy), 32'd0);
        step();

        $display("[TB] test 5: abort in tap 4 of window (2,1)");
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 0;
        step();
        start = 1'b0;
        for (int w = 0; w < 9; w++) begin
            runWindow(w / 4, w % 4, -1);
            step();
        end
        for (int t = 0; t < 5; t++) begin
            checkOutput($sformatf("abort_t%0d_addr", t), 32'(bus.pix_addr),
                        32'((2 + t / 3) * 6 + 1 + t % 3));
            if (t == 4) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd", 32'(bus.pix_rd), 32'd0);
        checkOutput("abort_en", 32'(bus.mac_en), 32'd0);
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("abort_idle%0d_done", i), 32'(done), 32'd0);
            checkOutput($sformatf("abort_idle%0d_busy", i), 32'(busy), 32'd0);
            step();
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 0;
        step();
        start = 1'b0;
        runWindow(0, 0, -1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        abort = 1'b0;

        $display("[TB] test 6: async reset in WAIT");
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 0;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        checkOutput("wait_busy", 32'(busy), 32'd1);
        checkOutput("wait_rd", 32'(bus.pix_rd), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_rd", 32'(bus.pix_rd), 32'd0);
        checkOutput("async_addr", 32'(bus.pix_addr), 32'd0);
        checkOutput("async_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 0;
        step();
        start = 1'b0;
        runWindow(0, 0, -1);
        step();
        checkOutput("post_reset_next_addr", 32'(bus.pix_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
